// File: rtl/mul_booth_iter.sv
// rtl/mul_booth_iter.sv - iterative radix-4 Booth multiplier with valid/ready handshake and flush
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   flush             synchronous cancel of any accepted or in-flight operation
//   in_valid/in_ready operand handshake (src1 multiplicand, src2 multiplier, signed_mul mode)
//   out_valid/out_ready result handshake
//   result            2*WIDTH-bit product, held until consumed
module mul_booth_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic                 signed_mul,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int N_ITER = (WIDTH + 2) / 2;
    localparam int AW     = 2 * WIDTH + 2;
    localparam int CW     = $clog2(N_ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [AW-1:0]    acc;
    // Multiplicand pre-shifted by 2*count so each digit term adds in place.
    logic [AW-1:0]    mcand;
    // Extended multiplier with the implicit zero at bit 0; shifted right by two
    // each iteration so the current Booth window is always the low three bits.
    logic [WIDTH+2:0] mplier;

    logic [2:0]       window;
    logic [AW-1:0]    term;
    logic [AW-1:0]    acc_next;
    logic             last_iter;
    logic             ext1;
    logic             ext2;

    assign in_ready  = (state == S_IDLE) && !flush && !reset;
    assign window    = mplier[2:0];
    assign last_iter = (count == CW'(N_ITER - 1));
    assign ext1      = signed_mul & src1[WIDTH-1];
    assign ext2      = signed_mul & src2[WIDTH-1];

    always_comb begin
        term = '0;
        case (window)
            3'b001, 3'b010: term = mcand;
            3'b011:         term = mcand << 1;
            3'b100:         term = -(mcand << 1);
            3'b101, 3'b110: term = -mcand;
            default:        term = '0;
        endcase
    end

    // Arithmetic wraps modulo 2^AW, which is exactly the Booth accumulation width.
    assign acc_next = acc + term;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{(WIDTH + 2){ext1}}, src1};
                        mplier <= {{2{ext2}}, src2, 1'b0};
                        acc    <= '0;
                        count  <= '0;
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= acc_next[2*WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
